evt_packet_deframer: RTL and testbench

Parametrised UART event-packet deframer sitting between the byte-level UART receiver and the gesture core's event input. It hunts for a sync header and assembles 5-byte (or 6-byte with checksum) event packets. It validates sync, checksum and coordinate range, and recovers from mid-packet stalls by timeout. Accepted events are buffered in a small FIFO behind a valid/ready stream, and saturating diagnostic counters track accepts and every drop cause.

---
 rtl/evt_packet_deframer_pkg.sv | 38 +++
 rtl/evt_packet_deframer_fifo.sv | 53 +++++
 rtl/evt_packet_deframer.sv | 181 ++++++++++++++++++
 tb/tb_evt_packet_deframer.sv | 360 ++++++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/evt_packet_deframer_pkg.sv
// Shared types and constants for the UART event-packet deframer.
package evt_pkg;

  typedef enum logic {
    HUNT    = 1'b0,
    COLLECT = 1'b1
  } state_t;

  // Byte offsets within a packet.
  localparam int unsigned HDR  = 0;
  localparam int unsigned XH   = 1;
  localparam int unsigned XL   = 2;
  localparam int unsigned YH   = 3;
  localparam int unsigned YL   = 4;
  localparam int unsigned CSUM = 5;

  localparam int unsigned MAX_PKT_BYTES = 6;

  // Diagnostic counter slots.
  localparam int unsigned NUM_CNT   = 6;
  localparam int unsigned C_OK      = 0;
  localparam int unsigned C_SYNC    = 1;
  localparam int unsigned C_CSUM    = 2;
  localparam int unsigned C_RANGE   = 3;
  localparam int unsigned C_OVF     = 4;
  localparam int unsigned C_TIMEOUT = 5;

  typedef struct packed {
    logic        pol;
    logic [15:0] x;
    logic [15:0] y;
  } evt_t;

  function automatic int unsigned pkt_bytes(input int unsigned csum_en);
    return (csum_en != 0) ? 6 : 5;
  endfunction

endpackage

// File: rtl/evt_packet_deframer_fifo.sv
// Synchronous show-ahead FIFO holding accepted events.
module evt_fifo #(
  parameter int unsigned WIDTH = 17,
  parameter int unsigned DEPTH = 8
) (
  input  logic                     clk,
  input  logic                     rst_n,
  input  logic                     push,
  input  logic [WIDTH-1:0]         din,
  input  logic                     pop,
  output logic [WIDTH-1:0]         dout,
  output logic [$clog2(DEPTH):0]   level,
  output logic                     full,
  output logic                     empty
);

  localparam int unsigned AW = $clog2(DEPTH);

  logic [WIDTH-1:0] r_mem [DEPTH];
  logic [AW-1:0]    r_wr;
  logic [AW-1:0]    r_rd;
  logic [AW:0]      r_level;
  logic             w_do_push;
  logic             w_do_pop;

  assign full      = (r_level == (AW+1)'(DEPTH));
  assign empty     = (r_level == '0);
  assign level     = r_level;
  assign dout      = r_mem[r_rd];
  assign w_do_push = push && !full;
  assign w_do_pop  = pop && !empty;

  always_ff @(posedge clk) begin
    if (w_do_push) r_mem[r_wr] <= din;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_wr    <= '0;
      r_rd    <= '0;
      r_level <= '0;
    end else begin
      if (w_do_push) r_wr <= r_wr + AW'(1);
      if (w_do_pop)  r_rd <= r_rd + AW'(1);
      case ({w_do_push, w_do_pop})
        2'b10:   r_level <= r_level + (AW+1)'(1);
        2'b01:   r_level <= r_level - (AW+1)'(1);
        default: r_level <= r_level;
      endcase
    end
  end

endmodule

// File: rtl/evt_packet_deframer.sv
// UART event-packet deframer: sync hunt, packet assembly, validation,
// timeout recovery, event FIFO and saturating drop counters.
module evt_packet_deframer
  import evt_pkg::*;
#(
  parameter logic [3:0]  SYNC_NIBBLE    = 4'hA,
  parameter int unsigned COORD_W        = 8,
  parameter int unsigned SENSOR_W       = 128,
  parameter int unsigned SENSOR_H       = 128,
  parameter int unsigned CHECKSUM_EN    = 0,
  parameter int unsigned TIMEOUT_CYCLES = 2084,
  parameter int unsigned FIFO_DEPTH     = 8,
  parameter int unsigned CNT_W          = 16
) (
  input  logic                          clk,
  input  logic                          rst_n,
  input  logic [7:0]                    rx_byte,
  input  logic                          rx_valid,
  output logic [COORD_W-1:0]            evt_x,
  output logic [COORD_W-1:0]            evt_y,
  output logic                          evt_pol,
  output logic                          evt_valid,
  input  logic                          evt_ready,
  output logic [$clog2(FIFO_DEPTH):0]   fifo_level,
  output logic                          busy,
  output logic [CNT_W-1:0]              cnt_ok,
  output logic [CNT_W-1:0]              cnt_drop_sync,
  output logic [CNT_W-1:0]              cnt_drop_csum,
  output logic [CNT_W-1:0]              cnt_drop_range,
  output logic [CNT_W-1:0]              cnt_drop_ovf,
  output logic [CNT_W-1:0]              cnt_drop_timeout
);

  localparam int unsigned PKT    = pkt_bytes(CHECKSUM_EN);
  localparam int unsigned IDLE_W = $clog2(TIMEOUT_CYCLES + 1);
  localparam int unsigned EVT_W  = 1 + 2 * COORD_W;

  state_t            r_state;
  state_t            w_state_nxt;
  logic [IDLE_W-1:0] r_idle;
  logic [IDLE_W-1:0] w_idle_nxt;
  logic [2:0]        r_idx;
  logic [2:0]        w_idx_nxt;
  logic [7:0]        r_buf [MAX_PKT_BYTES];
  logic [7:0]        w_pkt [MAX_PKT_BYTES];
  logic [CNT_W-1:0]  r_cnt [NUM_CNT];

  logic              w_timeout;
  logic              w_store;
  logic              w_final;
  logic              w_hunt_byte;
  logic              w_sync_ok;
  logic [7:0]        w_xor;
  logic              w_bad_csum;
  logic              w_bad_range;
  evt_t              w_evt;
  logic [NUM_CNT-1:0] w_inc;

  logic              w_push;
  logic              w_pop;
  logic              w_full;
  logic              w_empty;
  logic [EVT_W-1:0]  w_fifo_din;
  logic [EVT_W-1:0]  w_fifo_dout;

  // A timed-out COLLECT cycle hands its byte (if any) back to the hunter.
  assign w_timeout   = (r_state == COLLECT) && (r_idle == IDLE_W'(TIMEOUT_CYCLES));
  assign w_store     = (r_state == COLLECT) && !w_timeout && rx_valid;
  assign w_final     = w_store && (r_idx == 3'(PKT - 1));
  assign w_hunt_byte = rx_valid && ((r_state == HUNT) || w_timeout);
  assign w_sync_ok   = (rx_byte[7:4] == SYNC_NIBBLE);

  // Packet view with the in-flight byte merged at its slot.
  always_comb begin
    for (int unsigned i = 0; i < MAX_PKT_BYTES; i++) begin
      w_pkt[i] = (r_idx == 3'(i)) ? rx_byte : r_buf[i];
    end
  end

  assign w_evt.pol   = w_pkt[HDR][3];
  assign w_evt.x     = {w_pkt[XH], w_pkt[XL]};
  assign w_evt.y     = {w_pkt[YH], w_pkt[YL]};
  assign w_xor       = w_pkt[HDR] ^ w_pkt[XH] ^ w_pkt[XL] ^ w_pkt[YH] ^ w_pkt[YL];
  assign w_bad_csum  = (CHECKSUM_EN != 0) && (w_pkt[CSUM] != w_xor);
  assign w_bad_range = (32'(w_evt.x) >= SENSOR_W) || (32'(w_evt.y) >= SENSOR_H);

  always_comb begin
    w_inc            = '0;
    w_inc[C_SYNC]    = w_hunt_byte && !w_sync_ok;
    w_inc[C_TIMEOUT] = w_timeout;
    w_inc[C_CSUM]    = w_final && w_bad_csum;
    w_inc[C_RANGE]   = w_final && !w_bad_csum && w_bad_range;
    w_inc[C_OVF]     = w_final && !w_bad_csum && !w_bad_range && w_full;
    w_inc[C_OK]      = w_final && !w_bad_csum && !w_bad_range && !w_full;
  end

  assign w_push     = w_inc[C_OK];
  assign w_pop      = !w_empty && evt_ready;
  assign w_fifo_din = {w_evt.pol, w_evt.x[COORD_W-1:0], w_evt.y[COORD_W-1:0]};

  always_comb begin
    w_state_nxt = r_state;
    w_idle_nxt  = r_idle;
    w_idx_nxt   = r_idx;
    if (r_state == COLLECT) begin
      if (w_timeout) begin
        w_state_nxt = HUNT;
      end else if (rx_valid) begin
        w_idle_nxt = '0;
        w_idx_nxt  = r_idx + 3'd1;
        if (w_final) w_state_nxt = HUNT;
      end else begin
        w_idle_nxt = r_idle + IDLE_W'(1);
      end
    end
    if (w_hunt_byte && w_sync_ok) begin
      w_state_nxt = COLLECT;
      w_idx_nxt   = 3'd1;
      w_idle_nxt  = '0;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state <= HUNT;
      r_idle  <= '0;
      r_idx   <= '0;
    end else begin
      r_state <= w_state_nxt;
      r_idle  <= w_idle_nxt;
      r_idx   <= w_idx_nxt;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int unsigned i = 0; i < MAX_PKT_BYTES; i++) r_buf[i] <= '0;
    end else if (w_hunt_byte && w_sync_ok) begin
      r_buf[HDR] <= rx_byte;
    end else if (w_store) begin
      r_buf[r_idx] <= rx_byte;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int unsigned i = 0; i < NUM_CNT; i++) r_cnt[i] <= '0;
    end else begin
      for (int unsigned i = 0; i < NUM_CNT; i++) begin
        if (w_inc[i] && (r_cnt[i] != '1)) r_cnt[i] <= r_cnt[i] + CNT_W'(1);
      end
    end
  end

  evt_fifo #(
    .WIDTH(EVT_W),
    .DEPTH(FIFO_DEPTH)
  ) u_fifo (
    .clk   (clk),
    .rst_n (rst_n),
    .push  (w_push),
    .din   (w_fifo_din),
    .pop   (w_pop),
    .dout  (w_fifo_dout),
    .level (fifo_level),
    .full  (w_full),
    .empty (w_empty)
  );

  // Head is forced to zero when empty so stale memory never shows.
  assign {evt_pol, evt_x, evt_y} = w_empty ? '0 : w_fifo_dout;
  assign evt_valid        = !w_empty;
  assign busy             = (r_state == COLLECT);
  assign cnt_ok           = r_cnt[C_OK];
  assign cnt_drop_sync    = r_cnt[C_SYNC];
  assign cnt_drop_csum    = r_cnt[C_CSUM];
  assign cnt_drop_range   = r_cnt[C_RANGE];
  assign cnt_drop_ovf     = r_cnt[C_OVF];
  assign cnt_drop_timeout = r_cnt[C_TIMEOUT];

endmodule

// File: tb/tb_evt_packet_deframer.sv
// Bench for evt_packet_deframer: two configurations against a queue-style packet model.
module tb_evt_packet_deframer;

  logic clk = 1'b0;
  always #5 clk = ~clk;
  logic rst_n = 1'b1;

  logic [7:0] rxb [2];
  logic       rxv [2];
  logic       rdy [2];

  logic [7:0]  x0, y0;
  logic        pol0, val0, busy0;
  logic [3:0]  lvl0;
  logic [15:0] c0 [6];
  logic [5:0]  x1, y1;
  logic        pol1, val1, busy1;
  logic [2:0]  lvl1;
  logic [3:0]  c1 [6];

  int total = 0;
  int bad   = 0;

  evt_packet_deframer u0 (
    .clk(clk), .rst_n(rst_n), .rx_byte(rxb[0]), .rx_valid(rxv[0]),
    .evt_x(x0), .evt_y(y0), .evt_pol(pol0), .evt_valid(val0), .evt_ready(rdy[0]),
    .fifo_level(lvl0), .busy(busy0),
    .cnt_ok(c0[0]), .cnt_drop_sync(c0[1]), .cnt_drop_csum(c0[2]),
    .cnt_drop_range(c0[3]), .cnt_drop_ovf(c0[4]), .cnt_drop_timeout(c0[5])
  );

  evt_packet_deframer #(
    .COORD_W(6), .SENSOR_W(100), .SENSOR_H(50), .CHECKSUM_EN(1),
    .TIMEOUT_CYCLES(30), .FIFO_DEPTH(4), .CNT_W(4)
  ) u1 (
    .clk(clk), .rst_n(rst_n), .rx_byte(rxb[1]), .rx_valid(rxv[1]),
    .evt_x(x1), .evt_y(y1), .evt_pol(pol1), .evt_valid(val1), .evt_ready(rdy[1]),
    .fifo_level(lvl1), .busy(busy1),
    .cnt_ok(c1[0]), .cnt_drop_sync(c1[1]), .cnt_drop_csum(c1[2]),
    .cnt_drop_range(c1[3]), .cnt_drop_ovf(c1[4]), .cnt_drop_timeout(c1[5])
  );

  function automatic int p_pkt(input int m);  return (m == 0) ? 5 : 6;        endfunction
  function automatic int p_to(input int m);   return (m == 0) ? 2084 : 30;    endfunction
  function automatic int p_dep(input int m);  return (m == 0) ? 8 : 4;        endfunction
  function automatic int p_sw(input int m);   return (m == 0) ? 128 : 100;    endfunction
  function automatic int p_sh(input int m);   return (m == 0) ? 128 : 50;     endfunction
  function automatic int p_cw(input int m);   return (m == 0) ? 8 : 6;        endfunction
  function automatic int p_cmax(input int m); return (m == 0) ? 65535 : 15;   endfunction

  task automatic check(input string name, input int act, input int exp);
    total++;
    if (act != exp) begin
      bad++;
      if (bad <= 40) $display("FAIL %s: got %0d expected %0d", name, act, exp);
    end
  endtask

  // Behavioural model: collected bytes, idle gap, event queue, counters.
  int min_pkt [2];
  int mn      [2];
  int midle   [2];
  int mbuf    [2][6];
  int mfifo   [2][16];
  int mhead   [2];
  int mcnt    [2];
  int mc      [2][6];

  task automatic mreset(input int m);
    min_pkt[m] = 0; mn[m] = 0; midle[m] = 0; mhead[m] = 0; mcnt[m] = 0;
    for (int k = 0; k < 6; k++) mc[m][k] = 0;
  endtask

  task automatic msat(input int m, input int k);
    if (mc[m][k] < p_cmax(m)) mc[m][k]++;
  endtask

  task automatic mstep(input int m);
    int pop, full, hb, push, ev, x, y, xr, cw, mask, b;
    pop  = (mcnt[m] > 0 && rdy[m]) ? 1 : 0;
    full = (mcnt[m] == p_dep(m)) ? 1 : 0;
    hb   = rxv[m] ? 1 : 0;
    b    = int'(rxb[m]);
    push = 0;
    ev   = 0;
    if (min_pkt[m] != 0) begin
      if (midle[m] == p_to(m)) begin
        min_pkt[m] = 0;
        msat(m, 5);
      end else begin
        hb = 0;
        if (rxv[m]) begin
          mbuf[m][mn[m]] = b;
          mn[m]++;
          midle[m] = 0;
          if (mn[m] == p_pkt(m)) begin
            min_pkt[m] = 0;
            x  = mbuf[m][1] * 256 + mbuf[m][2];
            y  = mbuf[m][3] * 256 + mbuf[m][4];
            xr = mbuf[m][0] ^ mbuf[m][1] ^ mbuf[m][2] ^ mbuf[m][3] ^ mbuf[m][4];
            if (p_pkt(m) == 6 && mbuf[m][5] != xr) msat(m, 2);
            else if (x >= p_sw(m) || y >= p_sh(m)) msat(m, 3);
            else if (full != 0) msat(m, 4);
            else begin
              push = 1;
              cw   = p_cw(m);
              mask = (1 << cw) - 1;
              ev   = (((mbuf[m][0] >> 3) & 1) << (2 * cw)) | ((x & mask) << cw) | (y & mask);
              msat(m, 0);
            end
          end
        end else begin
          midle[m]++;
        end
      end
    end
    if (hb != 0) begin
      if ((b >> 4) == 'hA) begin
        mbuf[m][0] = b; mn[m] = 1; min_pkt[m] = 1; midle[m] = 0;
      end else begin
        msat(m, 1);
      end
    end
    if (pop != 0) begin mhead[m] = (mhead[m] + 1) % 16; mcnt[m]--; end
    if (push != 0) begin mfifo[m][(mhead[m] + mcnt[m]) % 16] = ev; mcnt[m]++; end
  endtask

  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      mreset(0); mreset(1);
    end else begin
      mstep(0); mstep(1);
    end
  end

  always @(negedge clk) begin : cmp
    int dv, dev, dl, db, ee;
    int dc [6];
    for (int m = 0; m < 2; m++) begin
      if (m == 0) begin
        dv = int'(val0); dev = int'({pol0, x0, y0}); dl = int'(lvl0); db = int'(busy0);
        for (int k = 0; k < 6; k++) dc[k] = int'(c0[k]);
      end else begin
        dv = int'(val1); dev = int'({pol1, x1, y1}); dl = int'(lvl1); db = int'(busy1);
        for (int k = 0; k < 6; k++) dc[k] = int'(c1[k]);
      end
      ee = (mcnt[m] > 0) ? mfifo[m][mhead[m]] : 0;
      check($sformatf("u%0d_valid", m), dv, (mcnt[m] > 0) ? 1 : 0);
      check($sformatf("u%0d_event", m), dev, ee);
      check($sformatf("u%0d_level", m), dl, mcnt[m]);
      check($sformatf("u%0d_busy", m), db, min_pkt[m]);
      for (int k = 0; k < 6; k++) check($sformatf("u%0d_cnt%0d", m, k), dc[k], mc[m][k]);
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic put(input int m, input logic [7:0] b);
    tick();
    rxb[m] = b;
    rxv[m] = 1'b1;
  endtask

  task automatic rel(input int m);
    tick();
    rxv[m] = 1'b0;
  endtask

  task automatic send(input int m, input logic [47:0] p, input int n);
    for (int i = 0; i < n; i++) put(m, p[8*(n-1-i) +: 8]);
  endtask

  task automatic idle(input int m, input int g);
    repeat (g) begin
      tick();
      rxv[m] = 1'b0;
      rdy[m] = ($urandom_range(0, 3) != 0);
    end
  endtask

  task automatic rnd_run(input int m, input int n);
    logic [7:0] b [6];
    logic [7:0] gb;
    int x, y, len, g;
    for (int k = 0; k < n; k++) begin
      rdy[m] = ($urandom_range(0, 3) != 0);
      if ($urandom_range(0, 4) == 0) begin
        gb = 8'($urandom);
        if (gb[7:4] == 4'hA) gb[7:4] = 4'h5;
        put(m, gb);
      end
      b[0] = {4'hA, 4'($urandom)};
      x = ($urandom_range(0, 7) == 0) ? int'($urandom_range(0, 65535)) : int'($urandom_range(0, p_sw(m) + 10));
      y = ($urandom_range(0, 7) == 0) ? int'($urandom_range(0, 65535)) : int'($urandom_range(0, p_sh(m) + 10));
      b[1] = 8'(x >> 8); b[2] = 8'(x); b[3] = 8'(y >> 8); b[4] = 8'(y);
      b[5] = b[0] ^ b[1] ^ b[2] ^ b[3] ^ b[4];
      if ($urandom_range(0, 5) == 0) b[5] = b[5] ^ 8'h10;
      len = p_pkt(m);
      if ($urandom_range(0, (m == 0) ? 40 : 8) == 0) len = int'($urandom_range(1, p_pkt(m) - 1));
      for (int i = 0; i < len; i++) begin
        put(m, b[i]);
        rdy[m] = ($urandom_range(0, 3) != 0);
        g = int'($urandom_range(0, 2));
        if (m == 1 && $urandom_range(0, 9) == 0) g = int'($urandom_range(p_to(m) - 1, p_to(m) + 1));
        if (i == len - 1 && len < p_pkt(m)) g = int'($urandom_range(p_to(m) - 1, p_to(m) + 1));
        idle(m, g);
      end
    end
  endtask

  initial begin
    #900000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog");
  end

  initial begin
    for (int m = 0; m < 2; m++) begin
      rxb[m] = 8'h00; rxv[m] = 1'b0; rdy[m] = 1'b1;
    end
    #2 rst_n = 1'b0;
    repeat (3) tick();
    rst_n = 1'b1;

    check("rst_valid", int'(val0), 0);
    check("rst_x", int'(x0), 0);
    check("rst_level", int'(lvl0), 0);
    check("rst_busy", int'(busy0), 0);
    check("rst_cnt_ok", int'(c0[0]), 0);
    check("rst_u1_valid", int'(val1), 0);

    // Clean packet and its latency.
    send(0, 48'hA8_00_05_00_07, 5);
    check("lat_before", int'(val0), 0);
    rel(0);
    check("lat_valid", int'(val0), 1);
    check("clean_x", int'(x0), 5);
    check("clean_y", int'(y0), 7);
    check("clean_pol", int'(pol0), 1);
    check("clean_ok", int'(c0[0]), 1);

    // Garbage then a packet.
    put(0, 8'h3C); put(0, 8'h11);
    send(0, 48'hA0_00_01_00_02, 5);
    rel(0);
    check("sync_cnt", int'(c0[1]), 2);
    check("sync_x", int'(x0), 1);
    check("sync_y", int'(y0), 2);
    check("sync_pol", int'(pol0), 0);

    // Range drop at x == SENSOR_W.
    send(0, 48'hA0_00_80_00_00, 5);
    rel(0);
    tick();
    check("range_cnt", int'(c0[3]), 1);
    check("range_noevt", int'(val0), 0);

    // Overflow with the consumer stalled, then ordered drain.
    rdy[0] = 1'b0;
    for (int i = 0; i < 9; i++) send(0, {8'hA0, 8'h00, 8'(i), 8'h00, 8'(i + 1)}, 5);
    rel(0);
    check("ovf_level", int'(lvl0), 8);
    check("ovf_cnt", int'(c0[4]), 1);
    check("ovf_ok", int'(c0[0]), 10);
    rdy[0] = 1'b1;
    for (int i = 0; i < 8; i++) begin
      check("drain_valid", int'(val0), 1);
      check("drain_x", int'(x0), i);
      check("drain_y", int'(y0), i + 1);
      tick();
    end
    check("drain_empty", int'(val0), 0);

    // Timeout after two bytes, one cycle either side of the limit.
    send(0, 48'hA0_00, 2);
    rel(0);
    repeat (2084) tick();
    check("to_busy_hold", int'(busy0), 1);
    check("to_cnt_hold", int'(c0[5]), 0);
    tick();
    check("to_busy_fall", int'(busy0), 0);
    check("to_cnt", int'(c0[5]), 1);
    send(0, 48'hA8_00_0A_00_0B, 5);
    rel(0);
    check("to_after_ok", int'(c0[0]), 11);
    check("to_after_x", int'(x0), 10);

    // Reset mid-packet with a non-empty FIFO.
    rdy[0] = 1'b0;
    send(0, 48'hA0_00_03_00_03, 5);
    send(0, 48'hA0_00_01, 3);
    rel(0);
    check("pre_rst_busy", int'(busy0), 1);
    rst_n = 1'b0;
    #1;
    check("mid_rst_valid", int'(val0), 0);
    check("mid_rst_level", int'(lvl0), 0);
    check("mid_rst_busy", int'(busy0), 0);
    check("mid_rst_ok", int'(c0[0]), 0);
    check("mid_rst_x", int'(x0), 0);
    tick();
    rst_n = 1'b1;
    rdy[0] = 1'b1;
    send(0, 48'hA0_00_04_00_06, 5);
    rel(0);
    check("post_rst_ok", int'(c0[0]), 1);
    check("post_rst_x", int'(x0), 4);
    check("post_rst_y", int'(y0), 6);

    // Checksum configuration.
    send(1, 48'hA0_00_01_00_02_A3, 6);
    rel(1);
    check("cs_valid", int'(val1), 1);
    check("cs_x", int'(x1), 1);
    check("cs_y", int'(y1), 2);
    check("cs_ok", int'(c1[0]), 1);
    send(1, 48'hA0_00_01_00_02_A4, 6);
    rel(1);
    tick();
    check("cs_bad", int'(c1[2]), 1);
    check("cs_bad_noevt", int'(val1), 0);

    // Byte arriving on the timeout cycle starts a new packet.
    put(1, 8'hA0);
    rel(1);
    repeat (29) tick();
    put(1, 8'hA0);
    check("coll_busy", int'(busy1), 1);
    check("coll_to_hold", int'(c1[5]), 0);
    send(1, 48'h00_03_00_04_A7, 5);
    rel(1);
    check("coll_to", int'(c1[5]), 1);
    check("coll_ok", int'(c1[0]), 2);
    check("coll_x", int'(x1), 3);
    check("coll_y", int'(y1), 4);

    // Coordinate truncation to COORD_W bits.
    send(1, 48'hA0_00_46_00_31_D7, 6);
    rel(1);
    check("trunc_x", int'(x1), 6);
    check("trunc_y", int'(y1), 49);

    fork
      rnd_run(0, 300);
      rnd_run(1, 400);
    join
    tick();
    for (int m = 0; m < 2; m++) begin
      rxv[m] = 1'b0; rdy[m] = 1'b1;
    end
    repeat (20) tick();

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
